execute_stage: RTL

EXECUTE_STAGE -- requirements
Module: execute_stage

---
 rtl/execute_stage.sv | 105 ++++++++++
 1 files changed

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - EX stage: operand forwarding, ALU control decode, EX/MEM pipeline register
module execute_stage #(
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [WORD_WIDTH-1:0] id_a,
  input  logic [WORD_WIDTH-1:0] id_b,
  input  logic [WORD_WIDTH-1:0] id_imm,
  input  logic                  id_alu_src,
  input  logic [1:0]            id_alu_op,
  input  logic [5:0]            id_funct,
  input  logic [4:0]            id_dest,
  input  logic [4:0]            id_ctrl,
  input  logic [1:0]            fwd_a_sel,
  input  logic [1:0]            fwd_b_sel,
  input  logic [WORD_WIDTH-1:0] exm_fwd_data,
  input  logic [WORD_WIDTH-1:0] wb_fwd_data,
  input  logic                  stall,
  input  logic                  flush,
  output logic [WORD_WIDTH-1:0] alu_a,
  output logic [WORD_WIDTH-1:0] alu_b,
  output logic [3:0]            alu_opcode,
  input  logic [WORD_WIDTH-1:0] alu_result,
  input  logic                  alu_zero,
  output logic                  exm_valid,
  output logic                  exm_zero,
  output logic                  exm_illegal,
  output logic [WORD_WIDTH-1:0] exm_result,
  output logic [WORD_WIDTH-1:0] exm_store_data,
  output logic [4:0]            exm_dest,
  output logic [4:0]            exm_ctrl
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_NOR = 4'b1100;

  logic [WORD_WIDTH-1:0] fwd_b;
  logic                  illegal;

  // Forwarding muxes: EX/MEM (10) and MEM/WB (01) bypass the register file; 00 and 11 use it
  always_comb begin
    case (fwd_a_sel)
      2'b10:   alu_a = exm_fwd_data;
      2'b01:   alu_a = wb_fwd_data;
      default: alu_a = id_a;
    endcase
    case (fwd_b_sel)
      2'b10:   fwd_b = exm_fwd_data;
      2'b01:   fwd_b = wb_fwd_data;
      default: fwd_b = id_b;
    endcase
    alu_b = id_alu_src ? id_imm : fwd_b;
  end

  // ALU control: coarse class from main control, R-type refined by funct; unknown funct flagged
  always_comb begin
    alu_opcode = OP_ADD;
    illegal    = 1'b0;
    case (id_alu_op)
      2'b00: alu_opcode = OP_ADD;
      2'b01: alu_opcode = OP_SUB;
      2'b11: alu_opcode = OP_OR;
      default: begin
        case (id_funct)
          6'b100000: alu_opcode = OP_ADD;
          6'b100010: alu_opcode = OP_SUB;
          6'b100100: alu_opcode = OP_AND;
          6'b100101: alu_opcode = OP_OR;
          6'b100111: alu_opcode = OP_NOR;
          default: begin
            alu_opcode = OP_ADD;
            illegal    = 1'b1;
          end
        endcase
      end
    endcase
  end

  // EX/MEM register: reset > flush > stall > load; an invalid slot loads with no side effects
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      exm_valid      <= 1'b0;
      exm_zero       <= 1'b0;
      exm_illegal    <= 1'b0;
      exm_result     <= '0;
      exm_store_data <= '0;
      exm_dest       <= '0;
      exm_ctrl       <= '0;
    end else if (!stall) begin
      exm_valid      <= id_valid;
      exm_zero       <= alu_zero;
      exm_illegal    <= illegal & id_valid;
      exm_result     <= alu_result;
      exm_store_data <= fwd_b;
      exm_dest       <= id_dest;
      exm_ctrl       <= id_valid ? id_ctrl : 5'd0;
    end
  end

endmodule
